// File: rtl/checkbit_monitor_pkg.sv
// Shared types for the checkpoint-bus monitor: FSM states and verdict reason codes.
package checkbit_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUNNING,
      DONE
   } state_e;

   localparam logic [1:0] REASON_NONE    = 2'd0;
   localparam logic [1:0] REASON_FAIL    = 2'd1;
   localparam logic [1:0] REASON_TIMEOUT = 2'd2;
   localparam logic [1:0] REASON_SEQ     = 2'd3;

endpackage

// File: rtl/checkbit_monitor_if.sv
// Control/status bundle between the checkpoint monitor and whatever arms and reads it.
interface checkbit_monitor_if #(
   parameter int WIDTH          = 16,
   parameter int TIMEOUT_CYCLES = 30000
);
   localparam int EW = $clog2(TIMEOUT_CYCLES + 1);

   logic             arm;
   logic [WIDTH-1:0] checkbits;
   logic             code_valid;
   logic [WIDTH-1:0] code;
   logic             started;
   logic             done;
   logic             passed;
   logic [1:0]       reason;
   logic [EW-1:0]    elapsed;

   modport master (
      output arm, checkbits,
      input  code_valid, code, started, done, passed, reason, elapsed
   );

   modport slave (
      input  arm, checkbits,
      output code_valid, code, started, done, passed, reason, elapsed
   );
endinterface

// File: rtl/checkbit_monitor_filter.sv
// Synchronizes and debounces the raw checkpoint bus; pulses code_valid_o once per new stable code.
module checkbit_filter #(
   parameter int WIDTH         = 16,
   parameter int STABLE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic [WIDTH-1:0] checkbits_i,
   output logic [WIDTH-1:0] code_o,
   output logic             code_valid_o
);
   localparam int             CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

   logic [WIDTH-1:0] sync1_q, sync2_q, cb_q, code_q;
   logic [CW-1:0]    cnt_q;
   logic             code_valid_q;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         cb_q         <= '0;
         cnt_q        <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage takes the previous stage's old value, keeping all three flops.
         sync1_q <= checkbits_i;
         sync2_q <= sync1_q;
         cb_q    <= sync2_q;

         // A changed sample counts as the first sample of the new value.
         if (sync2_q != cb_q)
            cnt_q <= CW'(1);
         else if (cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;

         code_valid_q <= 1'b0;
         if (cnt_q == CNT_MAX && cb_q != code_q) begin
            code_q       <= cb_q;
            code_valid_q <= 1'b1;
         end
      end
   end

   assign code_o       = code_q;
   assign code_valid_o = code_valid_q;
endmodule

// File: rtl/checkbit_monitor.sv
// Checkpoint-bus monitor: tracks start->pass sequence with a timeout and latches a verdict.
module checkbit_monitor
   import checkbit_monitor_pkg::*;
#(
   parameter int               WIDTH          = 16,
   parameter logic [WIDTH-1:0] START_CODE     = WIDTH'(16'hAB60),
   parameter logic [WIDTH-1:0] PASS_CODE      = WIDTH'(16'hAB61),
   parameter logic [WIDTH-1:0] FAIL_CODE      = WIDTH'(16'hAB6F),
   parameter int               STABLE_CYCLES  = 4,
   parameter int               TIMEOUT_CYCLES = 30000
) (
   input logic               clock,
   input logic               resetb,
   checkbit_monitor_if.slave mon
);
   localparam int            EW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [EW-1:0] LAST = EW'(TIMEOUT_CYCLES - 1);

   logic [WIDTH-1:0] code_w;
   logic             code_valid_w;

   checkbit_filter #(
      .WIDTH        (WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clock       (clock),
      .resetb      (resetb),
      .checkbits_i (mon.checkbits),
      .code_o      (code_w),
      .code_valid_o(code_valid_w)
   );

   state_e        state_q;
   logic          started_q, done_q, passed_q;
   logic [1:0]    reason_q;
   logic [EW-1:0] elapsed_q;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= IDLE;
         started_q <= 1'b0;
         done_q    <= 1'b0;
         passed_q  <= 1'b0;
         reason_q  <= REASON_NONE;
         elapsed_q <= '0;
      end else if (mon.arm) begin
         // Arm outranks a coincident code_valid; that code is dropped for sequencing.
         state_q   <= ARMED;
         started_q <= 1'b0;
         done_q    <= 1'b0;
         passed_q  <= 1'b0;
         reason_q  <= REASON_NONE;
         elapsed_q <= '0;
      end else begin
         case (state_q)
            ARMED, RUNNING: begin
               // elapsed stops at LAST, which is also the timeout point, so it never wraps.
               if (elapsed_q != LAST)
                  elapsed_q <= elapsed_q + 1'b1;

               if (code_valid_w && code_w == FAIL_CODE) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  reason_q <= REASON_FAIL;
               end else if (code_valid_w && code_w == PASS_CODE) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  passed_q <= (state_q == RUNNING);
                  reason_q <= (state_q == RUNNING) ? REASON_NONE : REASON_SEQ;
               end else if (state_q == ARMED && code_valid_w && code_w == START_CODE) begin
                  state_q   <= RUNNING;
                  started_q <= 1'b1;
               end else if (elapsed_q == LAST) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  reason_q <= REASON_TIMEOUT;
               end
            end
            IDLE, DONE: ;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mon.code       = code_w;
   assign mon.code_valid = code_valid_w;
   assign mon.started    = started_q;
   assign mon.done       = done_q;
   assign mon.passed     = passed_q;
   assign mon.reason     = reason_q;
   assign mon.elapsed    = elapsed_q;
endmodule

// File: tb/tb_checkbit_monitor.sv
// Directed bench for checkbit_monitor: pass, timeout, glitch, sequence error, fail/re-arm, reset.
module tb_checkbit_monitor;
   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 200;

   logic clock  = 1'b0;
   logic resetb = 1'b0;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   checkbit_monitor_if #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT)) mon ();

   checkbit_monitor #(
      .WIDTH         (WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock (clock),
      .resetb(resetb),
      .mon   (mon)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_arm();
      mon.arm = 1'b1;
      tick();
      mon.arm = 1'b0;
   endtask

   initial begin
      int seen;
      mon.arm       = 1'b0;
      mon.checkbits = '0;

      // Reset state
      #1;
      check("rst_code",       32'(mon.code),       32'h0);
      check("rst_code_valid", 32'(mon.code_valid), 32'h0);
      check("rst_started",    32'(mon.started),    32'h0);
      check("rst_done",       32'(mon.done),       32'h0);
      check("rst_passed",     32'(mon.passed),     32'h0);
      check("rst_reason",     32'(mon.reason),     32'h0);
      check("rst_elapsed",    32'(mon.elapsed),    32'h0);
      ticks(2);
      resetb = 1'b1;
      ticks(2);

      // Pass sequence: arm at edge A, AB60 seen from A+1, AB61 from A+11
      do_arm();
      check("p_arm_elapsed", 32'(mon.elapsed), 32'd0);
      check("p_arm_done",    32'(mon.done),    32'd0);
      mon.checkbits = 16'hAB60;
      ticks(6);
      check("p_cv_early",    32'(mon.code_valid), 32'd0);
      tick();
      check("p_cv_start",    32'(mon.code_valid), 32'd1);
      check("p_code_start",  32'(mon.code),       32'hAB60);
      check("p_started_lat", 32'(mon.started),    32'd0);
      tick();
      check("p_started",     32'(mon.started),    32'd1);
      check("p_cv_onecyc",   32'(mon.code_valid), 32'd0);
      ticks(2);
      mon.checkbits = 16'hAB61;
      ticks(7);
      check("p_cv_pass",     32'(mon.code_valid), 32'd1);
      check("p_code_pass",   32'(mon.code),       32'hAB61);
      check("p_done_lat",    32'(mon.done),       32'd0);
      tick();
      check("p_done",        32'(mon.done),       32'd1);
      check("p_passed",      32'(mon.passed),     32'd1);
      check("p_reason",      32'(mon.reason),     32'd0);
      check("p_elapsed",     32'(mon.elapsed),    32'd18);
      tick();
      check("p_elapsed_hold", 32'(mon.elapsed),   32'd18);

      // Timeout: AB60 accepted, AB61 never arrives
      do_arm();
      mon.checkbits = 16'hAB60;
      ticks(198);
      check("t_elapsed_198", 32'(mon.elapsed), 32'd198);
      check("t_done_198",    32'(mon.done),    32'd0);
      tick();
      check("t_elapsed_199", 32'(mon.elapsed), 32'd199);
      check("t_done_199",    32'(mon.done),    32'd0);
      tick();
      check("t_done",        32'(mon.done),    32'd1);
      check("t_passed",      32'(mon.passed),  32'd0);
      check("t_reason",      32'(mon.reason),  32'd2);
      check("t_elapsed",     32'(mon.elapsed), 32'd199);
      check("t_started",     32'(mon.started), 32'd1);

      // Codes accepted while DONE leave the verdict alone
      mon.checkbits = 16'h0000;
      ticks(8);
      check("d_code",   32'(mon.code),   32'h0);
      check("d_reason", 32'(mon.reason), 32'd2);
      check("d_done",   32'(mon.done),   32'd1);

      // Glitch: 2-cycle AB61 inside AB60 is never accepted
      do_arm();
      mon.checkbits = 16'hAB60;
      ticks(8);
      check("g_started", 32'(mon.started), 32'd1);
      mon.checkbits = 16'hAB61;
      ticks(2);
      mon.checkbits = 16'hAB60;
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (mon.code_valid) seen++;
      end
      check("g_no_pulse", 32'(seen),      32'd0);
      check("g_code",     32'(mon.code),  32'hAB60);
      check("g_done",     32'(mon.done),  32'd0);

      // Sequence error: AB61 before AB60
      mon.checkbits = 16'h0000;
      ticks(8);
      do_arm();
      check("s_started_clr", 32'(mon.started), 32'd0);
      mon.checkbits = 16'hAB61;
      ticks(8);
      check("s_done",    32'(mon.done),    32'd1);
      check("s_reason",  32'(mon.reason),  32'd3);
      check("s_started", 32'(mon.started), 32'd0);
      check("s_passed",  32'(mon.passed),  32'd0);

      // Firmware fail, then re-arm and pass with fresh elapsed
      do_arm();
      mon.checkbits = 16'hAB60;
      ticks(8);
      check("f_started", 32'(mon.started), 32'd1);
      mon.checkbits = 16'hAB6F;
      ticks(8);
      check("f_done",   32'(mon.done),   32'd1);
      check("f_reason", 32'(mon.reason), 32'd1);
      check("f_passed", 32'(mon.passed), 32'd0);
      do_arm();
      check("r_done_clr", 32'(mon.done), 32'd0);
      mon.checkbits = 16'hAB60;
      ticks(8);
      check("r_started", 32'(mon.started), 32'd1);
      mon.checkbits = 16'hAB61;
      ticks(8);
      check("r_done",    32'(mon.done),    32'd1);
      check("r_passed",  32'(mon.passed),  32'd1);
      check("r_reason",  32'(mon.reason),  32'd0);
      check("r_elapsed", 32'(mon.elapsed), 32'd16);

      // Async reset mid-RUNNING
      mon.checkbits = 16'h0000;
      ticks(8);
      do_arm();
      mon.checkbits = 16'hAB60;
      ticks(8);
      check("x_started_pre", 32'(mon.started), 32'd1);
      mon.checkbits = 16'hAB61;
      ticks(3);
      resetb = 1'b0;
      #1;
      check("x_started", 32'(mon.started), 32'd0);
      check("x_done",    32'(mon.done),    32'd0);
      check("x_code",    32'(mon.code),    32'h0);
      check("x_elapsed", 32'(mon.elapsed), 32'd0);
      ticks(2);
      resetb = 1'b1;
      ticks(10);
      check("x_code_after", 32'(mon.code),    32'hAB61);
      check("x_no_verdict", 32'(mon.done),    32'd0);
      check("x_idle_start", 32'(mon.started), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
